// File: rtl/hash_table.sv
// Shared types for the hash-table data-table stage.
package hash_table;

    // Task opcodes; value k selects engine k.
    typedef enum logic [1:0] {
        OP_SEARCH  = 2'd0,
        OP_INSERT  = 2'd1,
        OP_DELETE  = 2'd2,
        OP_INSERT2 = 2'd3
    } opcode_t;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_CLEAR     = 2'd2
    } arb_state_t;

endpackage

// File: rtl/prio_arb.sv
// Lowest-index-first one-hot grant; purely combinational.
module prio_arb #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    // Walk up from bit 0 and grant the first requester.
    always_comb begin
        logic found;
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_table_ram_arb.sv
// Dispatches tasks to engines, arbitrates engine RAM traffic, returns read
// tags and runs the zero-fill clear sweep of the data RAM.
module data_table_ram_arb
    import hash_table::*;
#(
    parameter int unsigned ENG_CNT     = 4,
    parameter int unsigned OPC_WIDTH   = 2,
    parameter int unsigned A_WIDTH     = 10,
    parameter int unsigned D_WIDTH     = 64,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [OPC_WIDTH-1:0]         opcode_i,
    input  logic                         task_valid_i,
    output logic                         task_ready_o,
    output logic [ENG_CNT-1:0]           eng_valid_o,
    input  logic [ENG_CNT-1:0]           eng_ready_i,
    input  logic [ENG_CNT-1:0]           eng_busy_i,
    input  logic [ENG_CNT-1:0]           eng_rd_en_i,
    input  logic [ENG_CNT*A_WIDTH-1:0]   eng_rd_addr_i,
    output logic [ENG_CNT-1:0]           eng_rd_gnt_o,
    output logic [ENG_CNT-1:0]           eng_rd_valid_o,
    input  logic [ENG_CNT-1:0]           eng_wr_en_i,
    input  logic [ENG_CNT*A_WIDTH-1:0]   eng_wr_addr_i,
    input  logic [ENG_CNT*D_WIDTH-1:0]   eng_wr_data_i,
    output logic [ENG_CNT-1:0]           eng_wr_gnt_o,
    input  logic                         update_en_i,
    input  logic [A_WIDTH-1:0]           update_addr_i,
    input  logic [D_WIDTH-1:0]           update_data_i,
    input  logic                         clear_ram_run_i,
    output logic                         clear_ram_done_o,
    output logic                         ram_rd_en_o,
    output logic [A_WIDTH-1:0]           ram_rd_addr_o,
    input  logic [D_WIDTH-1:0]           ram_rd_data_i,
    output logic                         ram_wr_en_o,
    output logic [A_WIDTH-1:0]           ram_wr_addr_o,
    output logic [D_WIDTH-1:0]           ram_wr_data_o
);

    localparam int unsigned IDX_W = (ENG_CNT > 1) ? $clog2(ENG_CNT) : 1;
    localparam logic [A_WIDTH-1:0] ADDR_LAST = '1;

    arb_state_t                          state_q, state_d;
    logic [A_WIDTH-1:0]                  clear_addr_q, clear_addr_d;
    logic                                done_q, done_d;
    logic [RAM_LATENCY-1:0]              rv_q, rv_d;
    logic [RAM_LATENCY-1:0][IDX_W-1:0]   ridx_q, ridx_d;

    logic [ENG_CNT-1:0]                  sel_mask;
    logic                                op_in_range;
    logic                                may_issue;
    logic [ENG_CNT-1:0]                  rd_gnt_raw;
    logic [ENG_CNT-1:0]                  wr_gnt_raw;
    logic [A_WIDTH-1:0]                  rd_addr;
    logic [IDX_W-1:0]                    rd_idx;
    logic                                clear_gnt;

    // Read data travels straight from the RAM to the engines.
    logic unused_rd_data;
    assign unused_rd_data = ^ram_rd_data_i;

    prio_arb #(.N(ENG_CNT)) u_rd_arb (
        .req_i (eng_rd_en_i),
        .gnt_o (rd_gnt_raw)
    );

    prio_arb #(.N(ENG_CNT)) u_wr_arb (
        .req_i (eng_wr_en_i),
        .gnt_o (wr_gnt_raw)
    );

    // Task dispatch: issue only in IDLE with every other engine quiet.
    always_comb begin
        sel_mask     = ENG_CNT'(1) << opcode_i;
        op_in_range  = 32'(opcode_i) < ENG_CNT;
        may_issue    = (state_q == ST_IDLE) && ((eng_busy_i & ~sel_mask) == '0);
        task_ready_o = 1'b0;
        eng_valid_o  = '0;
        if (!rst_i) begin
            if (op_in_range) begin
                task_ready_o = may_issue && ((eng_ready_i & sel_mask) != '0);
                eng_valid_o  = (task_valid_i && may_issue) ? sel_mask : '0;
            end else begin
                task_ready_o = (state_q == ST_IDLE);
            end
        end
    end

    // Read port: grant, address mux and granted engine index.
    always_comb begin
        eng_rd_gnt_o = rst_i ? '0 : rd_gnt_raw;
        rd_addr      = '0;
        rd_idx       = '0;
        for (int i = 0; i < int'(ENG_CNT); i++) begin
            if (rd_gnt_raw[i]) begin
                rd_addr = eng_rd_addr_i[i*A_WIDTH +: A_WIDTH];
                rd_idx  = IDX_W'(i);
            end
        end
        ram_rd_en_o   = |eng_rd_gnt_o;
        ram_rd_addr_o = rd_addr;
    end

    // Return pipe: tag enters at grant, leaves RAM_LATENCY cycles later.
    always_comb begin
        rv_d      = '0;
        ridx_d    = '0;
        rv_d[0]   = |eng_rd_gnt_o;
        ridx_d[0] = rd_idx;
        for (int i = 1; i < int'(RAM_LATENCY); i++) begin
            rv_d[i]   = rv_q[i-1];
            ridx_d[i] = ridx_q[i-1];
        end
        eng_rd_valid_o = rv_q[RAM_LATENCY-1] ? (ENG_CNT'(1) << ridx_q[RAM_LATENCY-1]) : '0;
    end

    // Write port: update beats clear, clear beats engines.
    always_comb begin
        clear_gnt     = 1'b0;
        eng_wr_gnt_o  = '0;
        ram_wr_en_o   = 1'b0;
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        if (!rst_i) begin
            if (update_en_i) begin
                ram_wr_en_o   = 1'b1;
                ram_wr_addr_o = update_addr_i;
                ram_wr_data_o = update_data_i;
            end else if (state_q == ST_CLEAR) begin
                clear_gnt     = 1'b1;
                ram_wr_en_o   = 1'b1;
                ram_wr_addr_o = clear_addr_q;
            end else if (eng_wr_en_i != '0) begin
                ram_wr_en_o  = 1'b1;
                eng_wr_gnt_o = wr_gnt_raw;
                for (int i = 0; i < int'(ENG_CNT); i++) begin
                    if (wr_gnt_raw[i]) begin
                        ram_wr_addr_o = eng_wr_addr_i[i*A_WIDTH +: A_WIDTH];
                        ram_wr_data_o = eng_wr_data_i[i*D_WIDTH +: D_WIDTH];
                    end
                end
            end
        end
    end

    // Control next state: wait for engines to drain, then sweep every address.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_ram_run_i) begin
                    state_d      = ST_WAIT_IDLE;
                    clear_addr_d = '0;
                end
            end
            ST_WAIT_IDLE: begin
                if (eng_busy_i == '0) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clear_gnt) begin
                    if (clear_addr_q == ADDR_LAST) begin
                        state_d      = ST_IDLE;
                        clear_addr_d = '0;
                        done_d       = 1'b1;
                    end else begin
                        clear_addr_d = clear_addr_q + A_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                clear_addr_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            clear_addr_q <= '0;
            done_q       <= 1'b0;
            rv_q         <= '0;
            ridx_q       <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            done_q       <= done_d;
            rv_q         <= rv_d;
            ridx_q       <= ridx_d;
        end
    end

    assign clear_ram_done_o = done_q;

endmodule

// File: doc/data_table_ram_arb.md
# data_table_ram_arb

Parametrised dispatch and RAM-arbitration core for the hash-table data table. It routes each incoming command to one of `ENG_CNT` engines, keeps operations mutually exclusive, and arbitrates engine read/write requests onto one dual-port data RAM. It also returns tagged read-valid strobes to the requesting engine and runs a real zero-fill clear sweep. It sits between the head-table stage and the per-opcode engines.

## Interface
Parameters:
- `ENG_CNT`, 4, number of engines; opcode value k selects engine k.
- `OPC_WIDTH`, 2, opcode width.
- `A_WIDTH`, 10, data RAM address width.
- `D_WIDTH`, 64, data RAM word width.
- `RAM_LATENCY`, 2, RAM read latency in cycles (≥1).

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `opcode_i` in `OPC_WIDTH`: opcode of the presented task.
- `task_valid_i` in 1 / `task_ready_o` out 1: task handshake.
- `eng_valid_o` out `ENG_CNT`: one-hot task strobe to the engines.
- `eng_ready_i` in `ENG_CNT`: engine accepts a task.
- `eng_busy_i` in `ENG_CNT`: engine has a task in flight.
- `eng_rd_en_i` in `ENG_CNT`: per-engine read request.
- `eng_rd_addr_i` in `ENG_CNT*A_WIDTH`: per-engine read address.
- `eng_rd_gnt_o` out `ENG_CNT`: read granted this cycle.
- `eng_rd_valid_o` out `ENG_CNT`: `ram_rd_data_i` belongs to engine k this cycle.
- `eng_wr_en_i` in `ENG_CNT`, `eng_wr_addr_i` in `ENG_CNT*A_WIDTH`, `eng_wr_data_i` in `ENG_CNT*D_WIDTH`: per-engine write requests.
- `eng_wr_gnt_o` out `ENG_CNT`: write granted this cycle.
- `update_en_i` in 1, `update_addr_i` in `A_WIDTH`, `update_data_i` in `D_WIDTH`: external overwrite port.
- `clear_ram_run_i` in 1: request a full-RAM zero fill.
- `clear_ram_done_o` out 1: one-cycle pulse when the sweep completes.
- `ram_rd_en_o` out 1, `ram_rd_addr_o` out `A_WIDTH`, `ram_rd_data_i` in `D_WIDTH`: RAM port A.
- `ram_wr_en_o` out 1, `ram_wr_addr_o` out `A_WIDTH`, `ram_wr_data_o` out `D_WIDTH`: RAM port B.

## Operation
- Dispatch, combinational. For `opcode_i` = k with k < `ENG_CNT`:
  - `eng_valid_o[k]` = `task_valid_i` & `may_issue`.
  - `task_ready_o` = `eng_ready_i[k]` & `may_issue`.
  - `may_issue` = state IDLE & no engine j≠k busy.
- An opcode ≥ `ENG_CNT` is consumed and dropped: `task_ready_o`=1 in IDLE, no `eng_valid_o`.
- Read arbitration: fixed priority, lowest index wins. `eng_rd_gnt_o` is one-hot. `ram_rd_en_o` = any granted. Losing engines hold their request.
- Read return: a shift register of depth `RAM_LATENCY` carries {valid, engine index}. `eng_rd_valid_o[k]` asserts exactly `RAM_LATENCY` cycles after `eng_rd_gnt_o[k]`.
- Write priority, highest first:
  - `update_en_i`
  - clear sweep
  - engines, lowest index wins
- A losing write source sees its grant deasserted and retries. A stalled clear holds its address.
- FSM states:
  - IDLE --`clear_ram_run_i`--> WAIT_IDLE
  - WAIT_IDLE --(no engine busy)--> CLEAR
  - CLEAR --(write of address 2^`A_WIDTH`-1 granted)--> IDLE, with `clear_ram_done_o` pulsed on the following cycle.
- In WAIT_IDLE and CLEAR, `task_ready_o`=0 and no dispatch occurs. In CLEAR, `ram_wr_data_o`=0 at `clear_addr` whenever clear holds the port.
- `clear_ram_run_i` outside IDLE is ignored.

## Timing
- Dispatch and arbitration are combinational (zero latency). Read data returns at `RAM_LATENCY`.
- Clear sweep takes 2^`A_WIDTH` cycles plus one cycle per `update_en_i` stall. The `clear_addr` counter is `A_WIDTH` wide and is not allowed to wrap.
- Reset values:
  - state IDLE, `clear_addr` 0, return pipe empty.
  - `clear_ram_done_o`=0, `eng_rd_valid_o`=0.
- While `rst_i`=1: `task_ready_o`, `eng_valid_o`, all grants and `ram_*_en_o` are forced to 0.
- Reset mid-clear aborts the sweep: no done pulse, and the next run restarts at 0.
- Reset drops in-flight read tags.
- `update_en_i` and an engine write on the same cycle: update wins, and the engine retries next cycle.

## Structure
- Shared package `hash_table`: opcode enum (`OP_SEARCH`=0, `OP_INSERT`=1, `OP_DELETE`=2, `OP_INSERT2`=3) and the `arb_state_t` enum.
- Sub-module `prio_arb` (parametrised lowest-index-first one-hot grant), instantiated for the read and write paths.

## Test plan
- Opcode 1 valid, engine 1 ready, all idle -> `eng_valid_o`=4'b0010 and `task_ready_o`=1 the same cycle. Then opcode 0 while `eng_busy_i`=4'b0010 -> `task_ready_o`=0 until busy drops.
- Engines 0 and 2 both request reads at addresses 5 and 9 -> addr 5 granted first, addr 9 next cycle. `eng_rd_valid_o` is 4'b0001 then 4'b0100, 2 cycles after each grant.
- `update_en_i` with addr 3 and engine 3 write to addr 7 on the same cycle -> RAM writes 3 first, then 7. `eng_wr_gnt_o[3]` is low then high.
- `A_WIDTH`=4, `clear_ram_run_i` with engine 0 busy for 5 cycles -> WAIT_IDLE for 5 cycles, then 16 zero writes to addresses 0..15, then a one-cycle `clear_ram_done_o`. Tasks are stalled throughout.
- Clear at `A_WIDTH`=4 with `update_en_i` at sweep cycle 6 -> sweep holds address 6 for one extra cycle, and done arrives after 17 sweep cycles.
- `rst_i` asserted at sweep address 8 -> no done pulse. The next run writes starting at address 0, and opcode 3 with `ENG_CNT`=3 is dropped with `task_ready_o`=1.
